// File: rtl/udp_rx_parser.sv
// ---------------------------------------------------------------------------
// udp_rx_parser
//
// Receive-side UDP/IPv4/Ethernet parser sitting directly on the GMII receive
// pins. It hunts for preamble + SFD and walks the Ethernet, IPv4 and UDP
// headers. Frames addressed elsewhere are filtered out. For accepted frames
// it delivers the UDP payload as big-endian 32-bit words.
//
// Everything runs in the GMII receive clock domain.
//
// Optional feature (macro UDP_RX_IPCHK_EN):
//   When defined, the IPv4 header checksum is verified with a ones-complement
//   sum. Frames with a bad checksum are dropped silently. When undefined, the
//   checksum field is ignored and no adder is built.
//
// Parameters:
//   LOCAL_MAC   accepted destination MAC (broadcast is also accepted)
//   LOCAL_IP    accepted destination IPv4 address
//   LOCAL_PORT  accepted UDP destination port
//
// Ports:
//   clk             GMII rx clock (125 MHz)
//   rst_n           asynchronous active-low reset
//   gmii_rxdv       receive data valid
//   gmii_rxer       receive error
//   gmii_rxd[7:0]   receive byte
//   rx_start        pulse: frame passed all header checks
//   rx_data[31:0]   payload word, first byte in [31:24]
//   rx_data_valid   pulse: rx_data qualifier, one per word
//   rx_data_length  payload byte count, held from rx_start to next rx_start
//   rx_done         pulse: final payload word
//   rx_err          pulse: an accepted frame was aborted (rxdv drop / rxer)
// ---------------------------------------------------------------------------
module udp_rx_parser #(
  parameter logic [47:0] LOCAL_MAC  = 48'h000a3501fec0,
  parameter logic [31:0] LOCAL_IP   = 32'hc0a80002,
  parameter logic [15:0] LOCAL_PORT = 16'h1f90
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rxdv,
  input  logic        gmii_rxer,
  input  logic [7:0]  gmii_rxd,
  output logic        rx_start,
  output logic [31:0] rx_data,
  output logic        rx_data_valid,
  output logic [15:0] rx_data_length,
  output logic        rx_done,
  output logic        rx_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_ETH_HDR,
    S_IP_HDR,
    S_UDP_HDR,
    S_PAYLOAD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;          // byte index within the current section
  logic        mac_local_q, mac_local_d;
  logic        mac_bcast_q, mac_bcast_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [15:0] len_out_q, len_out_d;  // payload length, drives rx_data_length
  logic [31:0] word_q, word_d;
  logic [31:0] data_q, data_d;
  logic        armed_q, armed_d;
  logic        start_q, start_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        bad;        // header field mismatch on the current byte
  logic        hdr_state;  // any state where an aborted frame is silent
  logic        last_byte;  // current payload byte is the final one
  logic [7:0]  mac_byte;   // LOCAL_MAC byte expected at the current index

`ifdef UDP_RX_IPCHK_EN
  logic [15:0] csum_q, csum_d;
  logic [7:0]  csum_hi_q, csum_hi_d;
  logic [16:0] csum_raw;
  logic [15:0] csum_sum;

  // Ones-complement accumulate of {high byte, current byte}. A single
  // end-around fold is enough: 0xffff + 0xffff folds to 0xffff.
  always_comb begin
    csum_raw = {1'b0, csum_q} + {1'b0, csum_hi_q, gmii_rxd};
    csum_sum = csum_raw[15:0] + {15'd0, csum_raw[16]};
  end
`endif

  always_comb begin
    case (cnt_q[2:0])
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      default: mac_byte = LOCAL_MAC[7:0];
    endcase
  end

  // NOTE: every variable assigned in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mac_local_d = mac_local_q;
    mac_bcast_d = mac_bcast_q;
    udp_len_d   = udp_len_q;
    len_out_d   = len_out_q;
    word_d      = word_q;
    data_d      = data_q;
    start_d     = 1'b0;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    bad         = 1'b0;
    last_byte   = 1'b0;
    // Re-armed by any idle cycle. After reset this blocks hunting inside a
    // frame that was already in flight.
    armed_d     = armed_q | ~gmii_rxdv;
`ifdef UDP_RX_IPCHK_EN
    csum_d      = csum_q;
    csum_hi_d   = csum_hi_q;
`endif

    hdr_state = (state_q == S_PREAMBLE) || (state_q == S_ETH_HDR) ||
                (state_q == S_IP_HDR)   || (state_q == S_UDP_HDR);

    if (hdr_state && !gmii_rxdv) begin
      state_d = S_IDLE;
    end else if (hdr_state && gmii_rxer) begin
      state_d = S_DROP;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gmii_rxdv) begin
            if (armed_q && !gmii_rxer && gmii_rxd == 8'h55) begin
              state_d = S_PREAMBLE;
              cnt_d   = 16'd1;
            end else begin
              state_d = S_DROP;
            end
          end
        end

        S_PREAMBLE: begin
          if (gmii_rxd == 8'h55) begin
            // Saturate: only ">= 6" matters, long preambles must not wrap.
            if (cnt_q < 16'd7) cnt_d = cnt_q + 16'd1;
          end else if (gmii_rxd == 8'hd5 && cnt_q >= 16'd6) begin
            state_d     = S_ETH_HDR;
            cnt_d       = '0;
            mac_local_d = 1'b1;
            mac_bcast_d = 1'b1;
          end else begin
            bad = 1'b1;
          end
        end

        S_ETH_HDR: begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q < 16'd6) begin
            mac_local_d = mac_local_q & (gmii_rxd == mac_byte);
            mac_bcast_d = mac_bcast_q & (gmii_rxd == 8'hff);
            if (cnt_q == 16'd5 && !mac_local_d && !mac_bcast_d) bad = 1'b1;
          end
          if (cnt_q == 16'd12 && gmii_rxd != 8'h08) bad = 1'b1;
          if (cnt_q == 16'd13) begin
            if (gmii_rxd != 8'h00) bad = 1'b1;
            state_d = S_IP_HDR;
            cnt_d   = '0;
`ifdef UDP_RX_IPCHK_EN
            csum_d  = '0;
`endif
          end
        end

        S_IP_HDR: begin
          cnt_d = cnt_q + 16'd1;
          case (cnt_q)
            16'd0:  if (gmii_rxd != 8'h45)           bad = 1'b1;
            16'd9:  if (gmii_rxd != 8'h11)           bad = 1'b1;
            16'd16: if (gmii_rxd != LOCAL_IP[31:24]) bad = 1'b1;
            16'd17: if (gmii_rxd != LOCAL_IP[23:16]) bad = 1'b1;
            16'd18: if (gmii_rxd != LOCAL_IP[15:8])  bad = 1'b1;
            16'd19: if (gmii_rxd != LOCAL_IP[7:0])   bad = 1'b1;
            default: ;
          endcase
`ifdef UDP_RX_IPCHK_EN
          if (!cnt_q[0]) csum_hi_d = gmii_rxd;
          else           csum_d    = csum_sum;
          if (cnt_q == 16'd19 && csum_sum != 16'hffff) bad = 1'b1;
`endif
          if (cnt_q == 16'd19) begin
            state_d = S_UDP_HDR;
            cnt_d   = '0;
          end
        end

        S_UDP_HDR: begin
          cnt_d = cnt_q + 16'd1;
          case (cnt_q)
            16'd2: if (gmii_rxd != LOCAL_PORT[15:8]) bad = 1'b1;
            16'd3: if (gmii_rxd != LOCAL_PORT[7:0])  bad = 1'b1;
            16'd4: udp_len_d[15:8] = gmii_rxd;
            16'd5: udp_len_d[7:0]  = gmii_rxd;
            default: ;
          endcase
          if (cnt_q == 16'd7) begin
            cnt_d = '0;
            if (udp_len_q < 16'd8) begin
              state_d = S_DROP;
            end else if (udp_len_q == 16'd8) begin
              // Empty datagram: start and done in the same cycle.
              start_d   = 1'b1;
              done_d    = 1'b1;
              len_out_d = '0;
              state_d   = S_DROP;
            end else begin
              start_d   = 1'b1;
              len_out_d = udp_len_q - 16'd8;
              state_d   = S_PAYLOAD;
            end
          end
        end

        S_PAYLOAD: begin
          if (!gmii_rxdv) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (gmii_rxer) begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end else begin
            // Byte lane placement leaves later lanes zero, so a short final
            // word comes out zero-padded with no extra logic.
            case (cnt_q[1:0])
              2'd0:    word_d = {gmii_rxd, 24'h0};
              2'd1:    word_d = {word_q[31:24], gmii_rxd, 16'h0};
              2'd2:    word_d = {word_q[31:16], gmii_rxd, 8'h0};
              default: word_d = {word_q[31:8], gmii_rxd};
            endcase
            cnt_d     = cnt_q + 16'd1;
            last_byte = ((cnt_q + 16'd1) == len_out_q);
            if (cnt_q[1:0] == 2'd3 || last_byte) begin
              valid_d = 1'b1;
              data_d  = word_d;
            end
            if (last_byte) begin
              done_d  = 1'b1;
              state_d = S_DROP;
            end
          end
        end

        S_DROP: begin
          if (!gmii_rxdv) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase

      if (bad) state_d = S_DROP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  // NOTE: all state, including the word and length registers, is cleared
  // by reset. Outputs are therefore defined before the first frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mac_local_q <= 1'b0;
      mac_bcast_q <= 1'b0;
      udp_len_q   <= '0;
      len_out_q   <= '0;
      word_q      <= '0;
      data_q      <= '0;
      armed_q     <= 1'b0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef UDP_RX_IPCHK_EN
      csum_q      <= '0;
      csum_hi_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mac_local_q <= mac_local_d;
      mac_bcast_q <= mac_bcast_d;
      udp_len_q   <= udp_len_d;
      len_out_q   <= len_out_d;
      word_q      <= word_d;
      data_q      <= data_d;
      armed_q     <= armed_d;
      start_q     <= start_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef UDP_RX_IPCHK_EN
      csum_q      <= csum_d;
      csum_hi_q   <= csum_hi_d;
`endif
    end
  end

  assign rx_start       = start_q;
  assign rx_data        = data_q;
  assign rx_data_valid  = valid_q;
  assign rx_data_length = len_out_q;
  assign rx_done        = done_q;
  assign rx_err         = err_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// ---------------------------------------------------------------------------
// tb_udp_rx_parser
//
// Scoreboard bench for udp_rx_parser. Each frame is built as a byte list.
// A behavioural frame model predicts the output events and queues them.
// A monitor compares every cycle with a strobe against the queue head.
// ---------------------------------------------------------------------------
module tb_udp_rx_parser;

  localparam logic [47:0] MAC  = 48'h000a3501fec0;
  localparam logic [31:0] IP   = 32'hc0a80002;
  localparam logic [15:0] PORT = 16'h1f90;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [47:0] mac;
    logic [15:0] etype;
    logic [7:0]  vihl;
    logic [7:0]  proto;
    logic [31:0] ip;
    logic [15:0] port;
    logic [15:0] ulen;
    bit          csum_bad;
  } hdr_t;

  typedef struct {
    logic        start;
    logic        valid;
    logic        done;
    logic        err;
    logic [31:0] data;
    logic [15:0] len;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gmii_rxdv;
  logic        gmii_rxer;
  logic [7:0]  gmii_rxd;
  logic        rx_start;
  logic [31:0] rx_data;
  logic        rx_data_valid;
  logic [15:0] rx_data_length;
  logic        rx_done;
  logic        rx_err;

  ev_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  udp_rx_parser dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .gmii_rxdv      (gmii_rxdv),
    .gmii_rxer      (gmii_rxer),
    .gmii_rxd       (gmii_rxd),
    .rx_start       (rx_start),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_data_length (rx_data_length),
    .rx_done        (rx_done),
    .rx_err         (rx_err)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_ev(input logic s, input logic v, input logic d, input logic e,
                                  input logic [31:0] data, input logic [15:0] len);
    ev_t ev;
    ev.start = s; ev.valid = v; ev.done = d; ev.err = e;
    ev.data = data; ev.len = len;
    exp_q.push_back(ev);
  endfunction

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst_n && (rx_start || rx_data_valid || rx_done || rx_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 64'({rx_start, rx_data_valid, rx_done, rx_err}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_flags", 64'({rx_start, rx_data_valid, rx_done, rx_err}),
              64'({e.start, e.valid, e.done, e.err}));
        if (e.valid) check("rx_data", 64'(rx_data), 64'(e.data));
        if (e.start) check("rx_data_length", 64'(rx_data_length), 64'(e.len));
      end
    end
  end

  function automatic hdr_t good_hdr(input logic [15:0] ulen);
    hdr_t h;
    h.mac = MAC; h.etype = 16'h0800; h.vihl = 8'h45; h.proto = 8'h11;
    h.ip = IP; h.port = PORT; h.ulen = ulen; h.csum_bad = 1'b0;
    return h;
  endfunction

  function automatic bq_t ramp(input int n, input logic [7:0] first);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(first + 8'(i));
    return p;
  endfunction

  // Frame content after the SFD: Ethernet + IPv4 + UDP + payload, padded to
  // the 60-byte minimum, then 4 FCS bytes.
  function automatic bq_t build(input hdr_t h, input bq_t pay);
    bq_t         f;
    int unsigned s;
    logic [15:0] tot, cs;
    for (int i = 5; i >= 0; i--) f.push_back(h.mac[8*i +: 8]);
    for (int i = 0; i < 6; i++)  f.push_back(8'($urandom));
    f.push_back(h.etype[15:8]); f.push_back(h.etype[7:0]);
    tot = h.ulen + 16'd20;
    f.push_back(h.vihl); f.push_back(8'h00);
    f.push_back(tot[15:8]); f.push_back(tot[7:0]);
    f.push_back(8'($urandom)); f.push_back(8'($urandom));
    f.push_back(8'h40); f.push_back(8'h00);
    f.push_back(8'h40); f.push_back(h.proto);
    f.push_back(8'h00); f.push_back(8'h00);
    f.push_back(8'hc0); f.push_back(8'ha8); f.push_back(8'h00); f.push_back(8'h01);
    for (int i = 3; i >= 0; i--) f.push_back(h.ip[8*i +: 8]);
    s = 0;
    for (int k = 0; k < 10; k++) s += {16'h0, f[14+2*k], f[15+2*k]};
    while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
    cs = ~s[15:0];
    f[24] = cs[15:8];
    f[25] = cs[7:0] ^ {7'd0, h.csum_bad};
    f.push_back(8'($urandom)); f.push_back(8'($urandom));
    f.push_back(h.port[15:8]); f.push_back(h.port[7:0]);
    f.push_back(h.ulen[15:8]); f.push_back(h.ulen[7:0]);
    f.push_back(8'h00); f.push_back(8'h00);
    foreach (pay[i]) f.push_back(pay[i]);
    while (f.size() < 60) f.push_back(8'h00);
    for (int i = 0; i < 4; i++) f.push_back(8'($urandom));
    return f;
  endfunction

  // Reference model. `avail` content bytes are sent before rxdv falls;
  // `er` is the content index that carries rxer (-1: none).
  function automatic void model(input bq_t f, input int avail, input int er);
    logic [47:0] mac;
    logic [15:0] ulen, plen;
    logic [31:0] word;
    int unsigned s;
    if (avail < 42) return;
    if (er >= 0 && er < 42) return;
    mac = {f[0], f[1], f[2], f[3], f[4], f[5]};
    if (mac != MAC && mac != 48'hffff_ffff_ffff) return;
    if ({f[12], f[13]} != 16'h0800) return;
    if (f[14] != 8'h45 || f[23] != 8'h11) return;
    if ({f[30], f[31], f[32], f[33]} != IP) return;
`ifdef UDP_RX_IPCHK_EN
    s = 0;
    for (int k = 0; k < 10; k++) s += {16'h0, f[14+2*k], f[15+2*k]};
    while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
    if (s != 32'hffff) return;
`else
    s = 0;
`endif
    if ({f[36], f[37]} != PORT) return;
    ulen = {f[38], f[39]};
    if (ulen < 16'd8) return;
    plen = ulen - 16'd8;
    push_ev(1'b1, 1'b0, plen == 0, 1'b0, 32'h0, plen);
    word = 32'h0;
    for (int i = 0; i < int'(plen); i++) begin
      if (42 + i >= avail || 42 + i == er) begin
        push_ev(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 16'h0);
        return;
      end
      word = word | ({24'h0, f[42+i]} << (8 * (3 - (i % 4))));
      if (i % 4 == 3 || i == int'(plen) - 1) begin
        push_ev(1'b0, 1'b1, i == int'(plen) - 1, 1'b0, word, 16'h0);
        word = 32'h0;
      end
    end
  endfunction

  task automatic put(input logic [7:0] b, input logic dv, input logic er);
    gmii_rxd = b; gmii_rxdv = dv; gmii_rxer = er;
    @(posedge clk); #1;
  endtask

  task automatic send(input bq_t f, input int avail, input int er, input int gap);
    model(f, avail, er);
    for (int i = 0; i < 7; i++) put(8'h55, 1'b1, 1'b0);
    put(8'hd5, 1'b1, 1'b0);
    for (int i = 0; i < avail; i++) put(f[i], 1'b1, i == er);
    for (int i = 0; i < gap; i++) put(8'h00, 1'b0, 1'b0);
  endtask

  initial begin : stim
    bq_t  f, g;
    hdr_t h;
    int   plen, avail, er;

    rst_n = 1'b0; gmii_rxdv = 1'b0; gmii_rxer = 1'b0; gmii_rxd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_start", 64'(rx_start), 64'd0);
    check("reset_rx_data", 64'(rx_data), 64'd0);
    check("reset_rx_data_valid", 64'(rx_data_valid), 64'd0);
    check("reset_rx_data_length", 64'(rx_data_length), 64'd0);
    check("reset_rx_done", 64'(rx_done), 64'd0);
    check("reset_rx_err", 64'(rx_err), 64'd0);
    rst_n = 1'b1;
    put(8'h00, 1'b0, 1'b0);
    put(8'h00, 1'b0, 1'b0);

    // Directed cases.
    send(build(good_hdr(16'd20), ramp(12, 8'h28)), 64, -1, 1);
    send(build(good_hdr(16'd13), ramp(5, 8'h01)), 64, -1, 1);
    h = good_hdr(16'd20); h.port = 16'h1f91;
    send(build(h, ramp(12, 8'h28)), 64, -1, 1);
    send(build(good_hdr(16'd20), ramp(12, 8'h40)), 64, -1, 1);
    h = good_hdr(16'd20); h.ip = 32'hc0a80003;
    send(build(h, ramp(12, 8'h28)), 64, -1, 1);
    send(build(good_hdr(16'd20), ramp(12, 8'h50)), 64, -1, 1);
    h = good_hdr(16'd20); h.etype = 16'h0806;
    send(build(h, ramp(12, 8'h28)), 64, -1, 1);
    send(build(good_hdr(16'd20), ramp(12, 8'h60)), 64, -1, 1);
    h = good_hdr(16'd20); h.mac = 48'hffff_ffff_ffff;
    send(build(h, ramp(12, 8'h28)), 64, -1, 1);
    send(build(good_hdr(16'd20), ramp(12, 8'h28)), 42 + 6, -1, 1);
    send(build(good_hdr(16'd20), ramp(12, 8'h28)), 64, 42 + 2, 1);
    send(build(good_hdr(16'd8), ramp(0, 8'h00)), 64, -1, 1);
    h = good_hdr(16'd7);
    send(build(h, ramp(0, 8'h00)), 64, -1, 1);
    f = build(good_hdr(16'd16), ramp(8, 8'h70));
    send(f, f.size(), -1, 1);
    f[25] = f[25] ^ 8'h01;
    send(f, f.size(), -1, 1);

    // Reset mid-frame, with rxdv held high across release. The tail carries a
    // complete valid frame that must not be parsed.
    f = build(good_hdr(16'd20), ramp(12, 8'h28));
    g = build(good_hdr(16'd20), ramp(12, 8'h80));
    for (int i = 0; i < 7; i++) put(8'h55, 1'b1, 1'b0);
    put(8'hd5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) put(f[i], 1'b1, 1'b0);
    rst_n = 1'b0;
    put(f[20], 1'b1, 1'b0);
    check("midreset_rx_start", 64'(rx_start), 64'd0);
    check("midreset_rx_data_length", 64'(rx_data_length), 64'd0);
    put(f[21], 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) put(8'h55, 1'b1, 1'b0);
    put(8'hd5, 1'b1, 1'b0);
    foreach (g[i]) put(g[i], 1'b1, 1'b0);
    put(8'h00, 1'b0, 1'b0);
    send(build(good_hdr(16'd11), ramp(3, 8'h90)), 64, -1, 1);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      plen = $urandom_range(0, 40);
      h = good_hdr(16'(plen + 8));
      if ($urandom_range(0, 3) == 0) h.mac = 48'hffff_ffff_ffff;
      if ($urandom_range(0, 7) == 0) h.csum_bad = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 6))
          0: h.mac   = 48'h000a3501fec1;
          1: h.etype = 16'h0806;
          2: h.vihl  = 8'h46;
          3: h.proto = 8'h06;
          4: h.ip    = 32'hc0a80003;
          5: h.port  = 16'h1f91;
          default: h.ulen = 16'($urandom_range(0, 7));
        endcase
      end
      f = build(h, ramp(plen, 8'($urandom)));
      avail = f.size();
      if ($urandom_range(0, 5) == 0) avail = $urandom_range(30, f.size());
      er = -1;
      if ($urandom_range(0, 5) == 0) er = $urandom_range(0, f.size() - 1);
      send(f, avail, er, $urandom_range(1, 3));
    end

    repeat (20) put(8'h00, 1'b0, 1'b0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/udp_rx_parser.md
Name: udp_rx_parser

Overview:
- Receive-side counterpart of the UDP transmit path.
- Consumes raw GMII receive bytes, strips preamble and SFD, then the Ethernet, IPv4 and UDP headers.
- Filters frames by destination MAC, IP and UDP port, then delivers the UDP payload as big-endian 32-bit words with start, done and error strobes.
- Runs entirely in the GMII receive clock domain, between the PHY pins and user logic.

Parameters:
- LOCAL_MAC, 48'h000a3501fec0, accepted destination MAC; broadcast ff:ff:ff:ff:ff:ff is also accepted.
- LOCAL_IP, 32'hc0a80002, accepted destination IPv4 address (192.168.0.2).
- LOCAL_PORT, 16'h1f90, accepted UDP destination port (8080).

Ports:
- clk  input  1  GMII rx clock, 125 MHz.
- rst_n  input  1  asynchronous active-low reset.
- gmii_rxdv  input  1  receive data valid.
- gmii_rxer  input  1  receive error.
- gmii_rxd  input  8  receive byte.
- rx_start  output  1  one-cycle pulse when a frame passes all header checks.
- rx_data  output  32  payload word; first payload byte in [31:24].
- rx_data_valid  output  1  rx_data qualifier, one-cycle pulse per word.
- rx_data_length  output  16  payload byte count (UDP length − 8); valid from rx_start until the next rx_start.
- rx_done  output  1  one-cycle pulse on the final payload word.
- rx_err  output  1  one-cycle pulse when an accepted-so-far frame is aborted.

Behaviour:
- Reset: all outputs 0. State IDLE; byte counter, word shift register and length registers cleared. An asserted reset mid-frame discards the frame; after release the block waits for gmii_rxdv low before hunting again.
- Bytes are sampled on posedge clk only when gmii_rxdv=1.
- States:
  - IDLE: on rxdv=1 with byte 0x55 → PREAMBLE.
  - PREAMBLE: counts 0x55 bytes. On 0xD5 with ≥6 preceding 0x55 → ETH_HDR. Any other byte → DROP.
  - ETH_HDR: 14 bytes. Bytes 0-5 must equal LOCAL_MAC or broadcast; bytes 12-13 must be 0x0800. Mismatch → DROP.
  - IP_HDR: 20 bytes. Byte 0 must be 0x45, byte 9 must be 0x11, bytes 16-19 must equal LOCAL_IP. Mismatch → DROP.
  - UDP_HDR: 8 bytes. Bytes 2-3 must equal LOCAL_PORT; bytes 4-5 are the UDP length. Length <8 → DROP without rx_err.
    - Length == 8 → rx_start and rx_done both pulse in the cycle after the last header byte; rx_data_length=0; → DROP.
    - Otherwise → PAYLOAD, with rx_start pulsing in the cycle after the last UDP header byte and rx_data_length latched at the same time.
  - PAYLOAD: bytes shift into the word register MSB-first. rx_data_valid pulses the cycle after the 4th byte of each word.
    - Final partial word: unused low bytes are zero; it is emitted the cycle after the last payload byte.
    - rx_done coincides with the final rx_data_valid. Then → DROP.
  - DROP: ignore bytes (Ethernet padding, FCS) until rxdv=0, then → IDLE.
- Header mismatches are silent (no rx_err).
- rx_err pulses if either occurs after rx_start and before rx_done; the block then goes to DROP (or IDLE if rxdv is already low). rx_done does not pulse, and any partial word is discarded.
  - rxdv falls early.
  - gmii_rxer=1 with rxdv=1.
- rxer before rx_start → DROP silently.
- rxdv low in any header state → IDLE silently.
- Back-to-back frames separated by a single rxdv-low cycle must be parsed.
- Payload byte counter is 16 bits and compares against rx_data_length; no wrap is possible because UDP length ≤ 65535.

Optional Feature:
- Macro UDP_RX_IPCHK_EN.
- When defined: accumulate the ones-complement sum of the ten 16-bit IP header words with end-around carry. If the result ≠ 16'hffff at the end of IP_HDR → DROP silently; no rx_start.
- When undefined: the checksum field is ignored and no adder logic is instantiated.

Test Plan:
- Valid frame to LOCAL_MAC/LOCAL_IP/port 0x1f90, UDP length 20, payload 0x28..0x33 → rx_start once, rx_data_length=12, words 0x28292a2b, 0x2c2d2e2f, 0x30313233, rx_done on the third word, rx_err=0.
- UDP length 13 (payload 0x01..0x05) → words 0x01020304, 0x05000000; rx_done with the second; 46-byte-min Ethernet padding and FCS ignored.
- Destination port 0x1f91, or IP 0xc0a80003, or EtherType 0x0806 → no rx_start, rx_data_valid, rx_done or rx_err; the next valid frame after a 1-cycle gap parses correctly.
- Broadcast destination MAC with otherwise valid headers → accepted identically to the LOCAL_MAC case.
- Valid headers, rxdv dropped after 6 of 12 payload bytes → one rx_data_valid (first word), rx_err pulse, no rx_done. Repeat with rxer asserted on payload byte 3 → rx_err, no rx_data_valid.
- With UDP_RX_IPCHK_EN: frame with a correct checksum is accepted; the same frame with checksum byte XOR 0x01 → no rx_start. Without the macro, both frames are accepted.
